// File: rtl/map_ss_seq.sv
// Save-state sequencer for one mapper. Freezes the mapper through ss_act and
// walks its state bytes. Save streams the ID byte followed by registers
// 0..REG_CNT-1 to the host. Load checks the ID byte first, then writes
// REG_CNT bytes back into the mapper.
module map_ss_seq #(
  parameter int REG_CNT = 18,
  parameter int ID_ADDR = 127,
  parameter int HOLD    = 2
) (
  input  logic       m2,
  input  logic       map_rst_n,
  input  logic       cmd_start,
  input  logic       cmd_load,
  input  logic       cmd_abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] sv_dat,
  output logic       sv_valid,
  input  logic       sv_ready,
  input  logic [7:0] ld_dat,
  input  logic       ld_valid,
  output logic       ld_ready,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat
);

  typedef enum logic [2:0] {IDLE, ID_RD, SV_RD, SV_OUT, LD_ID, LD_WR, FIN, ERR} state_t;
  typedef enum logic [1:0] {WR_WAIT, WR_STROBE, WR_SETTLE} wr_ph_t;

  localparam logic [7:0] LAST      = 8'(REG_CNT);
  localparam logic [7:0] ID_A      = 8'(ID_ADDR);
  localparam logic [2:0] HOLD_LAST = 3'(HOLD - 1);

  state_t     state, state_nxt;
  wr_ph_t     wph;
  logic [7:0] idx, id_reg, dat;
  logic [2:0] hcnt;
  logic       load_mode;
  logic       hold_end;
  logic [7:0] idx_inc;

  assign hold_end = (hcnt == HOLD_LAST);
  assign idx_inc  = idx + 8'd1;
  // One data register serves both directions: captured read byte on save,
  // accepted load byte on load.
  assign sv_dat   = dat;
  assign ss_wdat  = dat;

  // State register.
  always_ff @(posedge m2 or negedge map_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!map_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and per-state output decode; cmd_abort overrides every state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_nxt = state;
    busy      = (state != IDLE);
    ss_act    = (state != IDLE);
    done      = 1'b0;
    sv_valid  = 1'b0;
    ld_ready  = 1'b0;
    ss_we     = 1'b0;
    ss_addr   = 8'h00;
    case (state)
      IDLE: if (cmd_start) state_nxt = ID_RD;
      ID_RD: begin
        ss_addr = ID_A;
        if (hold_end) state_nxt = load_mode ? LD_ID : SV_OUT;
      end
      SV_RD: begin
        ss_addr = idx;
        if (hold_end) state_nxt = SV_OUT;
      end
      SV_OUT: begin
        sv_valid = 1'b1;
        if (sv_ready) state_nxt = (idx == LAST) ? FIN : SV_RD;
      end
      LD_ID: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = (ld_dat == id_reg) ? LD_WR : ERR;
      end
      LD_WR: begin
        ss_addr  = idx;
        ld_ready = (wph == WR_WAIT);
        ss_we    = (wph == WR_STROBE);
        if (wph == WR_SETTLE && idx_inc == LAST) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over any handshake: nothing is accepted or written this cycle.
    if (state != IDLE && cmd_abort) begin
      state_nxt = ERR;
      ss_we     = 1'b0;
      ld_ready  = 1'b0;
      done      = 1'b0;
    end
  end

  // Datapath: index, hold counter, captured bytes, write phase, sticky error.
  always_ff @(posedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      idx       <= 8'h00;
      id_reg    <= 8'h00;
      dat       <= 8'h00;
      hcnt      <= 3'd0;
      wph       <= WR_WAIT;
      load_mode <= 1'b0;
      err       <= 1'b0;
    end else if (state == IDLE) begin
      if (cmd_start) begin
        load_mode <= cmd_load;
        err       <= 1'b0;
        idx       <= 8'h00;
        hcnt      <= 3'd0;
        wph       <= WR_WAIT;
      end
    end else if (cmd_abort) begin
      err  <= 1'b1;
      hcnt <= 3'd0;
      wph  <= WR_WAIT;
    end else begin
      case (state)
        ID_RD, SV_RD: begin
          if (hold_end) begin
            hcnt <= 3'd0;
            dat  <= ss_rdat;
            if (state == ID_RD) id_reg <= ss_rdat;
            else                idx    <= idx_inc;
          end else begin
            hcnt <= hcnt + 3'd1;
          end
        end
        LD_ID: if (ld_valid && ld_dat != id_reg) err <= 1'b1;
        LD_WR: begin
          case (wph)
            WR_WAIT: if (ld_valid) begin
              dat <= ld_dat;
              wph <= WR_STROBE;
            end
            WR_STROBE: wph <= WR_SETTLE;
            default: begin
              wph <= WR_WAIT;
              idx <= idx_inc;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_map_ss_seq.sv
// Bench for map_ss_seq: a simple mapper model, a host driver issuing save and
// load commands, and a compare process that checks the byte streams and
// mapper writes against expectations derived from the host-level rules.
module tb_map_ss_seq;

  localparam int REG_CNT = 18;
  localparam int ID_ADDR = 127;
  localparam int N_SV    = REG_CNT + 1;
  localparam int BUDGET  = 2000;

  logic       m2 = 1'b0;
  logic       map_rst_n = 1'b1;
  logic       cmd_start = 1'b0, cmd_load = 1'b0, cmd_abort = 1'b0;
  logic       busy, done, err;
  logic [7:0] sv_dat;
  logic       sv_valid;
  logic       sv_ready = 1'b0;
  logic [7:0] ld_dat = 8'h00;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic       ss_act, ss_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat;

  map_ss_seq #(.REG_CNT(REG_CNT), .ID_ADDR(ID_ADDR), .HOLD(2)) dut (
    .m2(m2), .map_rst_n(map_rst_n), .cmd_start(cmd_start), .cmd_load(cmd_load),
    .cmd_abort(cmd_abort), .busy(busy), .done(done), .err(err),
    .sv_dat(sv_dat), .sv_valid(sv_valid), .sv_ready(sv_ready),
    .ld_dat(ld_dat), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
    .ss_rdat(ss_rdat)
  );

  always #5 m2 = ~m2;

  // Mapper model: ID byte at ID_ADDR, registers elsewhere, written on ss_we.
  logic [7:0] regs    [0:127];
  logic [7:0] pre_img [0:127];
  logic       pre_req = 1'b0;
  logic [7:0] map_id  = 8'h00;

  assign ss_rdat = (ss_addr == 8'(ID_ADDR)) ? map_id : regs[ss_addr[6:0]];

  // Mapper register file: bulk preload from the driver, else ss_we writes.
  always @(posedge m2) begin
    if (pre_req)    regs <= pre_img;
    else if (ss_we) regs[ss_addr[6:0]] <= ss_wdat;
  end

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Expected save stream (driver-built) and load stream (driver-supplied).
  logic [7:0] exp_img [0:N_SV-1];
  logic [7:0] ld_img  [0:N_SV-1];

  // Compare-process state.
  int         sv_idx = 0, ld_k = 0, n_we = 0, n_done = 0;
  logic [7:0] got_sv [0:N_SV-1];
  logic       pend_v = 1'b0, ld_id_ok = 1'b0, op_load_m = 1'b0;
  logic [7:0] pend_a = 8'h00, pend_d = 8'h00;
  logic       prev_stall = 1'b0, prev_we = 1'b0;
  logic [7:0] prev_dat = 8'h00, prev_a = 8'h00, prev_d = 8'h00;

  // Per-cycle comparison against the host-level model, sampled mid-cycle.
  always @(negedge m2) begin
    if (!map_rst_n) begin
      sv_idx = 0; ld_k = 0; pend_v = 1'b0; prev_stall = 1'b0; prev_we = 1'b0;
    end else begin
      if (cmd_start && !busy) begin
        sv_idx = 0; ld_k = 0; pend_v = 1'b0; ld_id_ok = 1'b0; op_load_m = cmd_load;
      end
      check("act_eq_busy", 32'(ss_act), 32'(busy));
      if (done) n_done++;
      // Save stream: k-th accepted byte must be the k-th image byte.
      if (sv_valid && prev_stall) check("sv_hold", 32'(sv_dat), 32'(prev_dat));
      if (sv_valid && sv_ready) begin
        check("sv_in_range", 32'(sv_idx < N_SV), 1);
        if (sv_idx < N_SV) begin
          check("sv_dat", 32'(sv_dat), 32'(exp_img[sv_idx]));
          got_sv[sv_idx] = sv_dat;
        end
        sv_idx++;
      end
      prev_stall = sv_valid && !sv_ready;
      prev_dat   = sv_dat;
      // Writes: only during load, only for an accepted byte after a matching ID.
      if (prev_we) begin
        check("wr_addr_hold", 32'(ss_addr), 32'(prev_a));
        check("wr_dat_hold", 32'(ss_wdat), 32'(prev_d));
      end
      if (ss_we) begin
        n_we++;
        check("we_in_load", 32'({ss_act, op_load_m}), 32'h3);
        check("we_expected", 32'(pend_v), 1);
        check("we_addr", 32'(ss_addr), 32'(pend_a));
        check("we_dat", 32'(ss_wdat), 32'(pend_d));
        pend_v = 1'b0;
      end
      prev_we = ss_we;
      prev_a  = ss_addr;
      prev_d  = ss_wdat;
      // Load acceptance: byte 0 is the ID, byte k goes to address k-1.
      if (ld_valid && ld_ready && !cmd_abort) begin
        if (ld_k == 0) begin
          ld_id_ok = (ld_dat == map_id);
        end else begin
          check("ld_in_range", 32'(ld_k <= REG_CNT), 1);
          pend_v = ld_id_ok;
          pend_a = 8'(ld_k - 1);
          pend_d = ld_dat;
        end
        ld_k++;
      end
    end
  end

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic load_image(input logic [7:0] id, input bit rnd);
    map_id = id;
    for (int i = 0; i < 128; i++) pre_img[i] = rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
    pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
  endtask

  task automatic start_op(input logic load);
    cmd_start = 1'b1;
    cmd_load  = load;
    tick();
    cmd_start = 1'b0;
    cmd_load  = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_act", 32'(ss_act), 1);
    check("start_err_clr", 32'(err), 0);
  endtask

  // mode 0: always ready, 1: ready toggles every 3 cycles, 2: random.
  task automatic run_save(input int mode);
    int cyc = 0;
    int d0 = n_done;
    int w0 = n_we;
    exp_img[0] = map_id;
    for (int i = 0; i < REG_CNT; i++) exp_img[i+1] = regs[i];
    start_op(1'b0);
    while (busy && cyc < BUDGET) begin
      case (mode)
        0:       sv_ready = 1'b1;
        1:       sv_ready = ((cyc / 3) % 2) == 0;
        default: sv_ready = $urandom_range(0, 2) != 0;
      endcase
      cmd_start = (mode == 1 && cyc == 10);
      cmd_load  = cmd_start;
      tick();
      cyc++;
    end
    sv_ready  = 1'b0;
    cmd_start = 1'b0;
    cmd_load  = 1'b0;
    check("save_finished", 32'(busy), 0);
    check("save_bytes", sv_idx, N_SV);
    check("save_done", n_done - d0, 1);
    check("save_no_we", n_we - w0, 0);
    check("save_err", 32'(err), 0);
  endtask

  // stall: percent of cycles ld_valid is withheld; abort_after>0 aborts
  // right where the byte following that many writes would be accepted.
  task automatic run_load(input int stall, input int abort_after);
    int cyc = 0, ptr = 0, abort_cyc = -1;
    int d0 = n_done;
    int w0 = n_we;
    bit hs;
    start_op(1'b1);
    while (busy && cyc < BUDGET) begin
      cmd_abort = (cyc == abort_cyc);
      ld_valid  = (ptr < N_SV) && (cmd_abort || stall == 0 || $urandom_range(0, 99) >= stall);
      ld_dat    = (ptr < N_SV) ? ld_img[ptr] : 8'h00;
      @(negedge m2);
      hs = ld_valid && ld_ready && !cmd_abort;
      if (cmd_abort) check("abort_no_accept", 32'(ld_ready), 0);
      @(posedge m2);
      #1;
      if (hs) ptr++;
      cyc++;
      if (abort_after > 0 && abort_cyc < 0 && n_we == w0 + abort_after) abort_cyc = cyc + 1;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) check("abort_err_set", 32'(err), 1);
    end
    cmd_abort = 1'b0;
    ld_valid  = 1'b0;
    check("load_finished", 32'(busy), 0);
    if (abort_after > 0) begin
      check("abort_we_count", n_we - w0, abort_after);
      check("abort_idle_delay", cyc - abort_cyc, 2);
      check("abort_no_done", n_done - d0, 0);
      check("abort_err", 32'(err), 1);
    end else if (ld_img[0] != map_id) begin
      check("badid_err", 32'(err), 1);
      check("badid_no_we", n_we - w0, 0);
      check("badid_no_done", n_done - d0, 0);
    end else begin
      check("load_we_count", n_we - w0, REG_CNT);
      check("load_done", n_done - d0, 1);
      check("load_err", 32'(err), 0);
      check("load_consumed", ptr, N_SV);
      for (int i = 0; i < REG_CNT; i++) check("load_reg", 32'(regs[i]), 32'(ld_img[i+1]));
    end
  endtask

  task automatic set_seq_load(input logic [7:0] id);
    ld_img[0] = id;
    for (int i = 1; i < N_SV; i++) ld_img[i] = 8'hA0 + 8'(i - 1);
  endtask

  // Stimulus sequence.
  initial begin
    #1 map_rst_n = 1'b0;
    #1;
    check("rst_flags", 32'({busy, done, err, sv_valid, ld_ready, ss_act, ss_we}), 0);
    check("rst_buses", {8'h00, sv_dat, ss_addr, ss_wdat}, 0);
    @(posedge m2);
    @(posedge m2);
    #1 map_rst_n = 1'b1;
    tick();

    // Plain save, host always ready.
    load_image(8'h04, 1'b0);
    run_save(0);
    check("pin_sv0", 32'(got_sv[0]), 32'h04);
    check("pin_sv1", 32'(got_sv[1]), 32'h5A);
    check("pin_sv2", 32'(got_sv[2]), 32'h5B);
    check("pin_sv18", 32'(got_sv[18]), 32'h4B);

    // Save under backpressure, with an ignored cmd_start mid-operation.
    run_save(1);
    check("pin_bp_sv1", 32'(got_sv[1]), 32'h5A);

    // Sequential load.
    set_seq_load(8'h04);
    run_load(0, 0);
    check("pin_reg0", 32'(regs[0]), 32'hA0);
    check("pin_reg17", 32'(regs[17]), 32'hB1);
    check("pin_reg18", 32'(regs[18]), 32'h48);

    // Wrong ID, then a new command clears err.
    load_image(8'h04, 1'b0);
    set_seq_load(8'h05);
    run_load(0, 0);
    run_save(0);

    // Abort after the 5th write, coincident with the next byte offer.
    load_image(8'h04, 1'b0);
    set_seq_load(8'h04);
    run_load(0, 5);
    check("abort_reg4", 32'(regs[4]), 32'hA4);
    check("abort_reg5", 32'(regs[5]), 32'h5F);

    // Asynchronous reset mid-save, then a fresh save.
    load_image(8'h04, 1'b0);
    exp_img[0] = map_id;
    for (int i = 0; i < REG_CNT; i++) exp_img[i+1] = regs[i];
    start_op(1'b0);
    sv_ready = 1'b1;
    repeat (8) tick();
    check("mid_save_busy", 32'(busy), 1);
    @(posedge m2);
    #3 map_rst_n = 1'b0;
    #1;
    check("arst_flags", 32'({busy, done, err, sv_valid, ld_ready, ss_act, ss_we}), 0);
    check("arst_buses", {8'h00, sv_dat, ss_addr, ss_wdat}, 0);
    sv_ready = 1'b0;
    tick();
    map_rst_n = 1'b1;
    tick();
    run_save(0);
    check("restart_id", 32'(got_sv[0]), 32'h04);
    check("restart_r0", 32'(got_sv[1]), 32'h5A);

    // Randomized images, load with random stalls, read back with random ready.
    for (int r = 0; r < 4; r++) begin
      load_image(8'($urandom), 1'b1);
      ld_img[0] = map_id;
      for (int i = 1; i < N_SV; i++) ld_img[i] = 8'($urandom);
      run_load(40, 0);
      run_save(2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // Global time bound in case a wait never resolves.
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, %0d/%0d so far", pass_cnt, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/map_ss_seq.md
Name: map_ss_seq

Overview:
- Save-state sequencer for the mapper save-state port (ss_act / ss_we / ss_addr / ss_rdat / write data).
- On a host command it freezes the mapper and walks its state registers in order.
  - Save: streams register bytes out.
  - Load: streams bytes in.
- Checks the mapper ID byte first, so a state image is never loaded into the wrong mapper.
- Sits between the host save-state DMA and one mapper module.

Parameters:
- REG_CNT, 18, number of mapper state bytes at ss_addr 0..REG_CNT-1.
- ID_ADDR, 127, ss_addr holding the mapper ID byte.
- HOLD, 2, m2 cycles ss_addr is held stable before ss_rdat is sampled (range 1..7).

Ports:
- m2  in  1  block clock; all state changes on its rising edge.
- map_rst_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle start pulse; ignored unless idle.
- cmd_load  in  1  sampled with cmd_start: 0 = save, 1 = load.
- cmd_abort  in  1  terminate current operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky ID-mismatch or abort flag; cleared by next cmd_start.
- sv_dat  out  8  save byte.
- sv_valid  out  1  save byte valid.
- sv_ready  in  1  host accepts save byte.
- ld_dat  in  8  load byte.
- ld_valid  in  1  load byte valid.
- ld_ready  out  1  block accepts load byte.
- ss_act  out  1  mapper freeze / save-state mode.
- ss_we  out  1  mapper register write strobe.
- ss_addr  out  8  mapper save-state address.
- ss_wdat  out  8  mapper write data.
- ss_rdat  in  8  mapper read data (combinational from ss_addr).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Index counter 0.
- States: IDLE, ID_RD, SV_RD, SV_OUT, LD_ID, LD_WR, FIN, ERR.
- IDLE:
  - busy=0, ss_act=0.
  - cmd_start moves to ID_RD, latches cmd_load, clears err.
  - busy=1 and ss_act=1 from the next cycle until return to IDLE.
- ID_RD:
  - ss_addr=ID_ADDR for HOLD cycles.
  - Captures ss_rdat into id_reg.
  - Save goes to SV_OUT with sv_dat=id_reg (header byte).
  - Load goes to LD_ID.
- SV_OUT:
  - sv_valid=1, sv_dat stable until sv_valid & sv_ready.
  - On that handshake, if idx==REG_CNT go to FIN, else go to SV_RD.
- SV_RD:
  - ss_addr=idx held HOLD cycles.
  - Captures ss_rdat, idx increments, then SV_OUT.
- Save stream order: ID byte, then addr 0..REG_CNT-1; REG_CNT+1 bytes total.
- LD_ID:
  - ld_ready=1.
  - On ld_valid & ld_ready: if ld_dat==id_reg go to LD_WR, else set err and go to ERR.
  - No ss_we is issued before the ID matches.
- LD_WR:
  - ld_ready=1 only while waiting for a byte.
  - On handshake: ss_addr=idx, ss_wdat=ld_dat, ss_we=1 for exactly one cycle, with ss_addr/ss_wdat stable that cycle and the one after.
  - idx increments; after idx reaches REG_CNT, go to FIN.
- Load stream: ID byte + REG_CNT bytes.
- FIN: done=1 for one cycle, then IDLE (ss_act drops the same cycle busy drops).
- ERR: one cycle, then IDLE; err stays 1.
- Backpressure: any number of stall cycles on sv_ready / ld_valid; no byte is dropped or duplicated.
- ss_we is never asserted without ss_act, and never during save.
- cmd_abort in any non-IDLE state:
  - Next state ERR, err=1, ss_we forced 0 that cycle.
  - Registers already written stay written.
- Simultaneous cmd_abort and a handshake: abort wins; the byte is not consumed and not written.
- cmd_start while busy: ignored.
- Asynchronous reset mid-operation: immediate return to reset values, ss_act=0.
- idx is 8 bits and never exceeds REG_CNT. REG_CNT must be ≤ ID_ADDR; otherwise behaviour is undefined.

Test Plan:
- Save, mapper model ID=0x04, regs[i]=i^0x5A, sv_ready always 1 -> 19 bytes: 0x04, 0x5A, 0x5B, ...; done pulses once; ss_we never high.
- Save with sv_ready toggling every 3 cycles -> identical byte sequence; sv_dat stable while sv_valid & !sv_ready.
- Load, ID 0x04, then bytes 0xA0..0xB1 -> 18 ss_we pulses, addr 0..17, data matching; mapper model equals input; done=1, err=0.
- Load with first byte 0x05 -> err=1, zero ss_we pulses, return to IDLE; next cmd_start clears err.
- cmd_abort after the 5th load write -> exactly 5 writes, err=1, ss_act=0 two cycles later; abort coincident with a handshake produces no 6th write.
- map_rst_n low mid-save -> all outputs 0 asynchronously; a new save after release starts again at the ID byte.
